interrupt_controller: RTL and testbench

Interrupt source for the pipelined NAND CPU: it collects external interrupt lines, latches rising edges as pending, picks the highest-priority enabled line, and drives the request/vector side of the fetch unit's interrupt port. It pairs with the fetch unit, which consumes the request, acknowledges at an instruction boundary, and later signals return-from-interrupt. The controller holds the saved PC (EPC) for the active interrupt and supports one level of service (no nesting).

---
 rtl/nand_cpu_pkg.sv | 13 +
 rtl/irq_priority_enc.sv | 21 ++
 rtl/interrupt_controller.sv | 112 +++++++++++
 tb/tb_interrupt_controller.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nand_cpu_pkg.sv
// Shared types and widths for the NAND CPU and its interrupt controller.
package nand_cpu_pkg;

  localparam int unsigned IRQ_ID_W = 2;
  localparam int unsigned PC_W     = 8;

  typedef enum logic [1:0] {
    IRQ_IDLE,
    IRQ_REQUEST,
    IRQ_SERVICING
  } irq_state_t;

endpackage

// File: rtl/irq_priority_enc.sv
// Fixed-priority encoder: the lowest set index of the candidate vector wins.
module irq_priority_enc
  import nand_cpu_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0]  i_cand,
  output logic                o_any,
  output logic [IRQ_ID_W-1:0] o_id
);

  always_comb begin
    o_any = |i_cand;
    o_id  = '0;
    // Walk downwards so the lowest set index is the last one written.
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (i_cand[i]) o_id = IRQ_ID_W'(i);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-triggered interrupt controller with enable mask, one level of service and saved EPC.
module interrupt_controller
  import nand_cpu_pkg::*;
#(
  parameter int unsigned     NUM_IRQ  = 4,
  parameter logic [PC_W-1:0] VEC_BASE = 8'hF0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_IRQ-1:0]  irq_lines,
  input  logic                mask_we,
  input  logic [NUM_IRQ-1:0]  mask_wdata,
  output logic [NUM_IRQ-1:0]  mask,
  output logic                int_req,
  output logic [PC_W-1:0]     int_vector,
  input  logic                int_ack,
  input  logic [PC_W-1:0]     ack_pc,
  input  logic                int_return,
  output logic [PC_W-1:0]     epc,
  output logic                irq_active,
  output logic [IRQ_ID_W-1:0] active_id
);

  logic [NUM_IRQ-1:0]  r_prev, r_pending, r_mask;
  irq_state_t          r_state;
  logic [IRQ_ID_W-1:0] r_sel_id, r_active_id;
  logic                r_int_req, r_irq_active;
  logic [PC_W-1:0]     r_int_vector, r_epc;

  logic [NUM_IRQ-1:0]  w_edge, w_cand, w_sel_oh, w_clr, w_pending_d;
  logic                w_any, w_ack;
  logic [IRQ_ID_W-1:0] w_id;

  assign w_edge   = irq_lines & ~r_prev;
  assign w_cand   = r_pending & r_mask;
  assign w_sel_oh = NUM_IRQ'(1) << r_sel_id;
  assign w_ack    = (r_state == IRQ_REQUEST) && int_ack;
  assign w_clr    = w_ack ? w_sel_oh : '0;
  // A fresh edge on the line being acknowledged keeps it pending.
  assign w_pending_d = (r_pending & ~w_clr) | w_edge;

  irq_priority_enc #(
    .NUM_IRQ(NUM_IRQ)
  ) u_prio (
    .i_cand(w_cand),
    .o_any (w_any),
    .o_id  (w_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev    <= '0;
      r_pending <= '0;
      r_mask    <= '0;
    end else begin
      r_prev    <= irq_lines;
      r_pending <= w_pending_d;
      if (mask_we) r_mask <= mask_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IRQ_IDLE;
      r_sel_id     <= '0;
      r_int_req    <= 1'b0;
      r_int_vector <= '0;
      r_epc        <= '0;
      r_irq_active <= 1'b0;
      r_active_id  <= '0;
    end else begin
      case (r_state)
        IRQ_IDLE: begin
          if (w_any) begin
            r_state      <= IRQ_REQUEST;
            r_sel_id     <= w_id;
            r_int_req    <= 1'b1;
            r_int_vector <= VEC_BASE + PC_W'({w_id, 2'b00});
          end
        end
        IRQ_REQUEST: begin
          if (int_ack) begin
            r_state      <= IRQ_SERVICING;
            r_epc        <= ack_pc;
            r_active_id  <= r_sel_id;
            r_irq_active <= 1'b1;
            r_int_req    <= 1'b0;
          end else if (!(|(w_cand & w_sel_oh))) begin
            // Line was masked off before fetch took it; withdraw without consuming pending.
            r_state   <= IRQ_IDLE;
            r_int_req <= 1'b0;
          end
        end
        IRQ_SERVICING: begin
          if (int_return) begin
            r_state      <= IRQ_IDLE;
            r_irq_active <= 1'b0;
          end
        end
        default: r_state <= IRQ_IDLE;
      endcase
    end
  end

  assign mask       = r_mask;
  assign int_req    = r_int_req;
  assign int_vector = r_int_vector;
  assign epc        = r_epc;
  assign irq_active = r_irq_active;
  assign active_id  = r_active_id;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios plus randomized run against a behavioural model.
module tb_interrupt_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] irq_lines = '0;
  logic       mask_we = 1'b0;
  logic [3:0] mask_wdata = '0;
  logic       int_ack = 1'b0;
  logic [7:0] ack_pc = '0;
  logic       int_return = 1'b0;

  logic [3:0] mask, mask_b;
  logic       int_req, int_req_b, irq_active, irq_active_b;
  logic [7:0] int_vector, int_vector_b, epc, epc_b;
  logic [1:0] active_id, active_id_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  logic [3:0] m_prev, m_pending, m_mask;
  int         m_state;  // 0 idle, 1 requesting, 2 in service
  int         m_sel;
  logic       m_req, m_active;
  logic [7:0] m_vec, m_vec_b, m_epc;
  logic [1:0] m_aid;

  interrupt_controller #(.NUM_IRQ(4), .VEC_BASE(8'hF0)) dut (
    .clk(clk), .rst(rst), .irq_lines(irq_lines), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .mask(mask), .int_req(int_req), .int_vector(int_vector), .int_ack(int_ack), .ack_pc(ack_pc),
    .int_return(int_return), .epc(epc), .irq_active(irq_active), .active_id(active_id)
  );

  interrupt_controller #(.NUM_IRQ(4), .VEC_BASE(8'hFC)) dut_b (
    .clk(clk), .rst(rst), .irq_lines(irq_lines), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .mask(mask_b), .int_req(int_req_b), .int_vector(int_vector_b), .int_ack(int_ack),
    .ack_pc(ack_pc), .int_return(int_return), .epc(epc_b), .irq_active(irq_active_b),
    .active_id(active_id_b)
  );

  always #5 clk = ~clk;

  task automatic model_update();
    logic [3:0] edges, cand;
    int lo;
    if (rst) begin
      m_prev = '0; m_pending = '0; m_mask = '0; m_state = 0; m_sel = 0;
      m_req = 0; m_active = 0; m_vec = '0; m_vec_b = '0; m_epc = '0; m_aid = '0;
    end else begin
      edges  = irq_lines & ~m_prev;
      cand   = m_pending & m_mask;
      m_prev = irq_lines;
      lo = -1;
      for (int i = 3; i >= 0; i--) if (cand[i]) lo = i;
      if (m_state == 0) begin
        if (lo >= 0) begin
          m_state = 1; m_sel = lo; m_req = 1;
          m_vec   = 8'((240 + 4 * lo) % 256);
          m_vec_b = 8'((252 + 4 * lo) % 256);
        end
      end else if (m_state == 1) begin
        if (int_ack) begin
          m_pending[m_sel] = 1'b0;
          m_state = 2; m_epc = ack_pc; m_aid = 2'(m_sel); m_active = 1; m_req = 0;
        end else if (!cand[m_sel]) begin
          m_state = 0; m_req = 0;
        end
      end else begin
        if (int_return) begin
          m_state = 0; m_active = 0;
        end
      end
      m_pending = m_pending | edges;
      if (mask_we) m_mask = mask_wdata;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic write_mask(input logic [3:0] m);
    mask_we = 1'b1; mask_wdata = m; tick(); mask_we = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] lines);
    irq_lines = lines; tick(); irq_lines = '0;
  endtask

  task automatic ack(input logic [7:0] pc);
    int_ack = 1'b1; ack_pc = pc; tick(); int_ack = 1'b0;
  endtask

  task automatic ret();
    int_return = 1'b1; tick(); int_return = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    n_tests++;
    if ({mask, int_req, int_vector, epc, irq_active, active_id} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_state: mask=%b req=%b vec=%h epc=%h act=%b id=%0d, expected all zero",
               mask, int_req, int_vector, epc, irq_active, active_id);
    end
  endtask

  task automatic test_basic();
    write_mask(4'b0001);
    n_tests++;
    if (mask !== 4'b0001) begin
      n_fail++; $display("FAIL basic_mask: mask=%b expected 0001", mask);
    end
    pulse(4'b0001);
    n_tests++;
    if (int_req !== 1'b0) begin
      n_fail++; $display("FAIL basic_latency: req=%b one cycle after edge, expected 0", int_req);
    end
    tick();
    n_tests++;
    if (int_req !== 1'b1 || int_vector !== 8'hF0) begin
      n_fail++; $display("FAIL basic_req: req=%b vec=%h, expected req=1 vec=f0", int_req, int_vector);
    end
    ack(8'h23);
    n_tests++;
    if (int_req !== 1'b0 || irq_active !== 1'b1 || epc !== 8'h23 || active_id !== 2'd0) begin
      n_fail++;
      $display("FAIL basic_ack: req=%b act=%b epc=%h id=%0d, expected 0 1 23 0",
               int_req, irq_active, epc, active_id);
    end
    ret();
    n_tests++;
    if (irq_active !== 1'b0 || epc !== 8'h23) begin
      n_fail++; $display("FAIL basic_return: act=%b epc=%h, expected act=0 epc=23", irq_active, epc);
    end
  endtask

  task automatic test_priority_and_wrap();
    write_mask(4'b1111);
    pulse(4'b1010);
    tick();
    n_tests++;
    if (int_req !== 1'b1 || int_vector !== 8'hF4 || int_vector_b !== 8'h00) begin
      n_fail++;
      $display("FAIL prio_first: req=%b vec=%h wrapvec=%h, expected req=1 vec=f4 wrapvec=00",
               int_req, int_vector, int_vector_b);
    end
    ack(8'h10); ret(); tick();
    n_tests++;
    if (int_req !== 1'b1 || int_vector !== 8'hFC) begin
      n_fail++; $display("FAIL prio_second: req=%b vec=%h, expected req=1 vec=fc", int_req, int_vector);
    end
    ack(8'h11); ret();
  endtask

  task automatic test_masked_pending();
    write_mask(4'b0000);
    pulse(4'b0100);
    tick(); tick();
    n_tests++;
    if (int_req !== 1'b0) begin
      n_fail++; $display("FAIL masked_no_req: req=%b, expected 0", int_req);
    end
    write_mask(4'b0100);
    n_tests++;
    if (int_req !== 1'b0) begin
      n_fail++; $display("FAIL masked_early: req=%b right after mask write, expected 0", int_req);
    end
    tick();
    n_tests++;
    if (int_req !== 1'b1 || int_vector !== 8'hF8) begin
      n_fail++; $display("FAIL masked_req: req=%b vec=%h, expected req=1 vec=f8", int_req, int_vector);
    end
    ack(8'h30); ret();
  endtask

  task automatic test_mask_withdraw();
    write_mask(4'b0010);
    pulse(4'b0010);
    tick();
    n_tests++;
    if (int_req !== 1'b1 || int_vector !== 8'hF4) begin
      n_fail++; $display("FAIL withdraw_req: req=%b vec=%h, expected req=1 vec=f4", int_req, int_vector);
    end
    write_mask(4'b0000);
    tick();
    n_tests++;
    if (int_req !== 1'b0 || irq_active !== 1'b0) begin
      n_fail++; $display("FAIL withdraw_drop: req=%b act=%b, expected 0 0", int_req, irq_active);
    end
    write_mask(4'b0010);
    tick();
    n_tests++;
    if (int_req !== 1'b1 || int_vector !== 8'hF4) begin
      n_fail++; $display("FAIL withdraw_again: req=%b vec=%h, expected req=1 vec=f4", int_req, int_vector);
    end
    ack(8'h40); ret();
  endtask

  task automatic test_service_edges();
    write_mask(4'b0101);
    pulse(4'b0001);
    tick();
    ack(8'h55);
    pulse(4'b0101);
    tick();
    n_tests++;
    if (int_req !== 1'b0 || irq_active !== 1'b1 || epc !== 8'h55) begin
      n_fail++;
      $display("FAIL serv_hold: req=%b act=%b epc=%h, expected 0 1 55", int_req, irq_active, epc);
    end
    ret(); tick();
    n_tests++;
    if (int_req !== 1'b1 || int_vector !== 8'hF0) begin
      n_fail++; $display("FAIL serv_line0: req=%b vec=%h, expected req=1 vec=f0", int_req, int_vector);
    end
    // New edge on line 0 in the same cycle its pending bit is cleared
    irq_lines = 4'b0001; ack(8'h66); irq_lines = '0;
    ret(); tick();
    n_tests++;
    if (int_req !== 1'b1 || int_vector !== 8'hF0) begin
      n_fail++; $display("FAIL serv_setwins: req=%b vec=%h, expected req=1 vec=f0", int_req, int_vector);
    end
    ack(8'h67); ret(); tick();
    n_tests++;
    if (int_req !== 1'b1 || int_vector !== 8'hF8) begin
      n_fail++; $display("FAIL serv_line2: req=%b vec=%h, expected req=1 vec=f8", int_req, int_vector);
    end
    ack(8'h77); ret();
    ack(8'h99);
    n_tests++;
    if (int_req !== 1'b0 || irq_active !== 1'b0 || epc !== 8'h77) begin
      n_fail++;
      $display("FAIL stray_ack: req=%b act=%b epc=%h, expected 0 0 77", int_req, irq_active, epc);
    end
    ret();
    n_tests++;
    if (int_req !== 1'b0 || irq_active !== 1'b0 || active_id !== 2'd2) begin
      n_fail++;
      $display("FAIL stray_return: req=%b act=%b id=%0d, expected 0 0 2", int_req, irq_active, active_id);
    end
  endtask

  task automatic test_reset_mid_service();
    write_mask(4'b0001);
    pulse(4'b0001);
    tick();
    ack(8'hAA);
    n_tests++;
    if (irq_active !== 1'b1 || epc !== 8'hAA) begin
      n_fail++; $display("FAIL rst_setup: act=%b epc=%h, expected 1 aa", irq_active, epc);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    n_tests++;
    if ({mask, int_req, int_vector, epc, irq_active, active_id} !== 24'h0) begin
      n_fail++;
      $display("FAIL rst_mid_service: mask=%b req=%b vec=%h epc=%h act=%b id=%0d, expected all zero",
               mask, int_req, int_vector, epc, irq_active, active_id);
    end
  endtask

  task automatic test_random();
    logic [31:0] obs, exp_v;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 600; c++) begin
      irq_lines  = 4'($urandom);
      mask_we    = ($urandom_range(0, 7) == 0);
      mask_wdata = 4'($urandom);
      int_ack    = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      ack_pc     = 8'($urandom);
      int_return = (m_state == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      rst        = ($urandom_range(0, 149) == 0);
      tick();
      obs   = {mask, int_req, int_vector, int_vector_b, epc, irq_active, active_id};
      exp_v = {m_mask, m_req, m_vec, m_vec_b, m_epc, m_active, m_aid};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL random_cycle_%0d: got mask=%b req=%b vec=%h vecb=%h epc=%h act=%b id=%0d, expected mask=%b req=%b vec=%h vecb=%h epc=%h act=%b id=%0d",
                 c, mask, int_req, int_vector, int_vector_b, epc, irq_active, active_id,
                 m_mask, m_req, m_vec, m_vec_b, m_epc, m_active, m_aid);
      end
    end
    rst = 1'b0; irq_lines = '0; mask_we = 1'b0; int_ack = 1'b0; int_return = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority_and_wrap();
    test_masked_pending();
    test_mask_withdraw();
    test_service_edges();
    test_reset_mid_service();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
